// File: rtl/shift_add_multiplier.sv
// Multi-cycle 16x16 shift-add multiplier for MULT/MULTU. It issues one 16-bit
// add with carry-out per cycle and produces a 32-bit product for HI/LO.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | 16 add/shift iterations
// FIN   | apply sign, write product
// DONE  | one-cycle done pulse; start may chain straight into RUN
module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [16:0] hi;
  logic [15:0] lo;
  logic [15:0] mcand;
  logic        neg;

  logic [16:0] sum;
  logic [16:0] acc;
  logic [31:0] mag_prod;
  logic [15:0] a_mag;
  logic [15:0] b_mag;
  logic        capture;

  // Magnitude of 0x8000 wraps back to 0x8000, which is the correct unsigned value.
  assign a_mag    = (signed_op && a[15]) ? (~a + 16'd1) : a;
  assign b_mag    = (signed_op && b[15]) ? (~b + 16'd1) : b;
  assign sum      = {1'b0, hi[15:0]} + {1'b0, mcand};
  assign acc      = lo[0] ? sum : hi;
  assign mag_prod = {hi[15:0], lo};
  assign capture  = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == RUN) || (state == FIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == 5'd15) state_nxt = FIN;
      FIN:     state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= 5'd0;
      hi      <= 17'd0;
      lo      <= 16'd0;
      mcand   <= 16'd0;
      neg     <= 1'b0;
      product <= 32'd0;
    end else begin
      if (capture) begin
        mcand <= a_mag;
        lo    <= b_mag;
        hi    <= 17'd0;
        neg   <= signed_op && (a[15] ^ b[15]);
        count <= 5'd0;
      end else if (state == RUN) begin
        // Shift {acc, lo} right by one; the carry lands in hi[15] after the shift.
        hi    <= {1'b0, acc[16:1]};
        lo    <= {acc[0], lo[15:1]};
        count <= (count == 5'd15) ? 5'd0 : count + 5'd1;
      end else if (state == FIN) begin
        product <= neg ? (~mag_prod + 32'd1) : mag_prod;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed, table-driven bench for shift_add_multiplier: vector table plus
// hand-written handshake and mid-operation reset sequences.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_chk;
  int n_fail;
  logic [31:0] prev_prod;

  shift_add_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vs;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drives operands, lets edge E0 sample start, returns #1 after E0.
  task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input logic ts);
    a         = ta;
    b         = tb_;
    signed_op = ts;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  // Called #1 after E0; returns #1 after the edge that raised done.
  // inj > 0 pulses start (with other operands) so it is sampled at edge E<inj>.
  task automatic wait_result(input string nm, input logic [31:0] exp, input int inj);
    int  busy_cnt;
    int  lat;
    logic held_ok;
    busy_cnt = busy ? 1 : 0;
    lat      = -1;
    held_ok  = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (inj > 0 && cyc == inj) begin
        start     = 1'b1;
        a         = 16'hFFFF;
        b         = 16'hFFFF;
        signed_op = ~signed_op;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) busy_cnt++;
      if (product !== prev_prod) held_ok = 1'b0;
    end
    chk({nm, " latency"}, lat, 32'd17);
    chk({nm, " busy_cycles"}, busy_cnt, 32'd17);
    chk({nm, " product_held"}, {31'd0, held_ok}, 32'd1);
    chk({nm, " product"}, product, exp);
    chk({nm, " busy_in_done"}, {31'd0, busy}, 32'd0);
    prev_prod = exp;
  endtask

  task automatic done_drop(input string nm);
    @(posedge clk);
    #1;
    chk({nm, " done_pulse_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    prev_prod = 32'd0;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = 16'h0;
    b         = 16'h0;

    vecs[0]  = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[2]  = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1};
    vecs[3]  = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000};
    vecs[5]  = '{16'h0000, 16'hFFFF, 1'b1, 32'h00000000};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[7]  = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
    vecs[8]  = '{16'hFFFD, 16'hFFFB, 1'b1, 32'h0000000F};
    vecs[9]  = '{16'h0003, 16'hFFFB, 1'b1, 32'hFFFFFFF1};
    vecs[10] = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    vecs[11] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};

    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].va, vecs[i].vb, vecs[i].vs);
      wait_result($sformatf("vec%0d", i), vecs[i].exp, 0);
      done_drop($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
    end

    // start at E5 with different operands must be ignored
    launch(16'h0003, 16'h0005, 1'b0);
    wait_result("ignore_start", 32'h0000000F, 5);
    // chain a new start during the DONE cycle
    a         = 16'h0007;
    b         = 16'h0009;
    signed_op = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("chain done_dropped", {31'd0, done}, 32'd0);
    chk("chain busy_rose", {31'd0, busy}, 32'd1);
    wait_result("chain", 32'h0000003F, 0);
    done_drop("chain");

    // reset after E8 of 0x1234*0x5678
    launch(16'h1234, 16'h5678, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst product", product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_prod = 32'd0;
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        #1;
        if (done || busy) saw_done = 1'b1;
      end
      chk("midrst no_activity", {31'd0, saw_done}, 32'd0);
    end
    launch(16'h1234, 16'h5678, 1'b0);
    wait_result("after_rst", 32'h06260060, 0);
    done_drop("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
